// File: rtl/hazard_fwd_unit.sv
// Hazard-detection and operand-forwarding unit.
// A DEPTH-entry result scoreboard tracks in-flight destinations after EX.
// It forwards ready results to the ALU operand muxes, stalls decode on
// unresolved sources, and freezes while a load at LD_STAGE waits for memory.
module hazard_fwd_unit #(
    parameter int XLEN       = 32,
    parameter int REG_BITS   = 5,
    parameter int DEPTH      = 3,
    parameter int LD_STAGE   = 1,
    parameter int LD_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clk_en,
    input  logic                id_valid,
    input  logic [REG_BITS-1:0] id_rd,
    input  logic                id_rd_we,
    input  logic                id_is_load,
    input  logic [REG_BITS-1:0] id_rs1,
    input  logic [REG_BITS-1:0] id_rs2,
    input  logic                id_rs1_used,
    input  logic                id_rs2_used,
    input  logic [XLEN-1:0]     rf_rs1_data,
    input  logic [XLEN-1:0]     rf_rs2_data,
    input  logic [XLEN-1:0]     ex_result,
    input  logic                mem_rsp_valid,
    input  logic [XLEN-1:0]     mem_rsp_data,
    output logic [XLEN-1:0]     op_a,
    output logic [XLEN-1:0]     op_b,
    output logic                stall,
    output logic                mem_wait,
    output logic                wb_valid,
    output logic [REG_BITS-1:0] wb_rd,
    output logic [XLEN-1:0]     wb_data,
    output logic                ld_timeout
);

    localparam int CW = $clog2(LD_TIMEOUT + 1);

    // Scoreboard entries: index 0 is EX/MEM, index DEPTH-1 is writeback.
    logic [DEPTH-1:0]    e_valid;
    logic [DEPTH-1:0]    e_we;
    logic [DEPTH-1:0]    e_load;
    logic [DEPTH-1:0]    e_ok;
    logic [REG_BITS-1:0] e_rd   [DEPTH];
    logic [XLEN-1:0]     e_data [DEPTH];

    // Entry status as seen this cycle, folding in a load response arriving now.
    logic [DEPTH-1:0]    eff_ok;
    logic [XLEN-1:0]     eff_data [DEPTH];

    logic [CW-1:0]       wait_cnt;
    logic                timeout_q;

    logic                ld_waiting;
    logic                ld_resp;
    logic                advance;
    logic                issue;
    logic                hit_a;
    logic                hit_b;
    logic                rs1_unres;
    logic                rs2_unres;

    assign ld_waiting = e_valid[LD_STAGE] && e_load[LD_STAGE] && !e_ok[LD_STAGE];
    assign ld_resp    = ld_waiting && mem_rsp_valid;
    assign mem_wait   = ld_waiting && !mem_rsp_valid;
    assign advance    = clk_en && !mem_wait;
    assign issue      = id_valid && !stall;
    assign ld_timeout = timeout_q;

    // Effective entry data: a response accepted this cycle counts as ready,
    // so forwarding, shifting and writeback all see the captured value.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            eff_ok[i]   = e_ok[i];
            eff_data[i] = e_data[i];
        end
        if (ld_resp) begin
            eff_ok[LD_STAGE]   = 1'b1;
            eff_data[LD_STAGE] = mem_rsp_data;
        end
    end

    // Operand A: youngest matching writer wins; x0 always reads zero.
    always_comb begin
        op_a      = rf_rs1_data;
        rs1_unres = 1'b0;
        hit_a     = 1'b0;
        if (id_rs1 == '0) begin
            op_a = '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (!hit_a && e_valid[i] && e_we[i] && (e_rd[i] == id_rs1)) begin
                    hit_a = 1'b1;
                    if (eff_ok[i]) begin
                        op_a = eff_data[i];
                    end else begin
                        rs1_unres = 1'b1;
                    end
                end
            end
        end
    end

    // Operand B: same resolution rules as operand A.
    always_comb begin
        op_b      = rf_rs2_data;
        rs2_unres = 1'b0;
        hit_b     = 1'b0;
        if (id_rs2 == '0) begin
            op_b = '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (!hit_b && e_valid[i] && e_we[i] && (e_rd[i] == id_rs2)) begin
                    hit_b = 1'b1;
                    if (eff_ok[i]) begin
                        op_b = eff_data[i];
                    end else begin
                        rs2_unres = 1'b1;
                    end
                end
            end
        end
    end

    // Stall and writeback strobes, both suppressed while clk_en is low.
    always_comb begin
        stall    = clk_en && id_valid &&
                   (mem_wait || (id_rs1_used && rs1_unres) || (id_rs2_used && rs2_unres));
        wb_valid = advance && e_valid[DEPTH-1] && e_we[DEPTH-1] &&
                   (e_rd[DEPTH-1] != '0) && eff_ok[DEPTH-1];
        wb_rd    = e_rd[DEPTH-1];
        wb_data  = eff_data[DEPTH-1];
    end

    // Scoreboard shift: entries move one stage per advance; entry 0 takes the
    // decode instruction or a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            e_valid <= '0;
            e_we    <= '0;
            e_load  <= '0;
            e_ok    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                e_rd[i]   <= '0;
                e_data[i] <= '0;
            end
        end else if (advance) begin
            for (int unsigned i = DEPTH - 1; i > 0; i--) begin
                e_valid[i] <= e_valid[i-1];
                e_we[i]    <= e_we[i-1];
                e_load[i]  <= e_load[i-1];
                e_ok[i]    <= eff_ok[i-1];
                e_rd[i]    <= e_rd[i-1];
                e_data[i]  <= eff_data[i-1];
            end
            if (issue) begin
                e_valid[0] <= 1'b1;
                e_we[0]    <= id_rd_we;
                e_load[0]  <= id_is_load;
                e_ok[0]    <= !id_is_load;
                e_rd[0]    <= id_rd;
                e_data[0]  <= id_is_load ? '0 : ex_result;
            end else begin
                e_valid[0] <= 1'b0;
                e_we[0]    <= 1'b0;
                e_load[0]  <= 1'b0;
                e_ok[0]    <= 1'b0;
                e_rd[0]    <= '0;
                e_data[0]  <= '0;
            end
        end
    end

    // Memory-wait counter with a sticky timeout flag; the freeze itself persists.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else if (clk_en) begin
            if (mem_wait) begin
                if (wait_cnt != CW'(LD_TIMEOUT)) begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
                if (wait_cnt >= CW'(LD_TIMEOUT - 1)) begin
                    timeout_q <= 1'b1;
                end
            end else begin
                wait_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Self-checking bench for hazard_fwd_unit: directed scenarios followed by
// randomized traffic, all compared against an instruction-level pipeline model.
module tb_hazard_fwd_unit;

    localparam int XLEN = 32;
    localparam int RB   = 5;
    localparam int D    = 3;
    localparam int LDS  = 1;
    localparam int TO   = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            clk_en;
    logic            id_valid;
    logic [RB-1:0]   id_rd;
    logic            id_rd_we;
    logic            id_is_load;
    logic [RB-1:0]   id_rs1;
    logic [RB-1:0]   id_rs2;
    logic            id_rs1_used;
    logic            id_rs2_used;
    logic [XLEN-1:0] rf_rs1_data;
    logic [XLEN-1:0] rf_rs2_data;
    logic [XLEN-1:0] ex_result;
    logic            mem_rsp_valid;
    logic [XLEN-1:0] mem_rsp_data;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            stall;
    logic            mem_wait;
    logic            wb_valid;
    logic [RB-1:0]   wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            ld_timeout;

    int checks = 0;
    int errors = 0;
    logic obs_stall;
    logic obs_wait;

    hazard_fwd_unit #(
        .XLEN(XLEN), .REG_BITS(RB), .DEPTH(D), .LD_STAGE(LDS), .LD_TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .id_valid(id_valid), .id_rd(id_rd), .id_rd_we(id_rd_we), .id_is_load(id_is_load),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data), .ex_result(ex_result),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .op_a(op_a), .op_b(op_b), .stall(stall), .mem_wait(mem_wait),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .ld_timeout(ld_timeout)
    );

    always #5 clk = ~clk;

    // Reference model: one record per in-flight instruction, oldest at D-1.
    typedef struct packed {
        bit        v;
        bit [4:0]  rd;
        bit        we;
        bit        ld;
        bit        ok;
        bit [31:0] d;
    } rec_t;

    rec_t pipe [D];
    int   wcnt;
    bit   tmo;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit m_wait();
        return pipe[LDS].v && pipe[LDS].ld && !pipe[LDS].ok && !mem_rsp_valid;
    endfunction

    function automatic void m_fwd(input bit [4:0] src, input bit [31:0] rf,
                                  output bit [31:0] val, output bit unres);
        val   = rf;
        unres = 1'b0;
        if (src == 0) begin
            val = 0;
            return;
        end
        for (int i = 0; i < D; i++) begin
            if (pipe[i].v && pipe[i].we && pipe[i].rd == src) begin
                if (pipe[i].ok) val = pipe[i].d;
                else if (i == LDS && mem_rsp_valid) val = mem_rsp_data;
                else unres = 1'b1;
                return;
            end
        end
    endfunction

    // One clock: check outputs against the model, then advance the model.
    task automatic cycle();
        bit [31:0] ea, eb;
        bit ua, ub, w, st, adv, wbv;
        #1;
        w = m_wait();
        m_fwd(id_rs1, rf_rs1_data, ea, ua);
        m_fwd(id_rs2, rf_rs2_data, eb, ub);
        st  = clk_en && id_valid && (w || (id_rs1_used && ua) || (id_rs2_used && ub));
        adv = clk_en && !w;
        wbv = adv && pipe[D-1].v && pipe[D-1].we && pipe[D-1].rd != 0 && pipe[D-1].ok;
        chk("mem_wait", mem_wait, w);
        chk("stall", stall, st);
        chk("op_a", op_a, ea);
        chk("op_b", op_b, eb);
        chk("wb_valid", wb_valid, wbv);
        if (wbv) begin
            chk("wb_rd", wb_rd, pipe[D-1].rd);
            chk("wb_data", wb_data, pipe[D-1].d);
        end
        chk("ld_timeout", ld_timeout, tmo);
        obs_stall = stall;
        obs_wait  = mem_wait;
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < D; i++) pipe[i] = '0;
            wcnt = 0;
            tmo  = 1'b0;
        end else if (clk_en) begin
            if (w) begin
                wcnt++;
                if (wcnt >= TO) tmo = 1'b1;
            end else begin
                wcnt = 0;
                if (pipe[LDS].v && pipe[LDS].ld && !pipe[LDS].ok && mem_rsp_valid) begin
                    pipe[LDS].ok = 1'b1;
                    pipe[LDS].d  = mem_rsp_data;
                end
                for (int i = D - 1; i > 0; i--) pipe[i] = pipe[i-1];
                pipe[0] = '0;
                if (id_valid && !st)
                    pipe[0] = '{1'b1, id_rd, id_rd_we, id_is_load, !id_is_load,
                                id_is_load ? 32'h0 : ex_result};
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 0; clk_en = 1; id_valid = 0; id_rd = 0; id_rd_we = 0; id_is_load = 0;
        id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
        rf_rs1_data = 0; rf_rs2_data = 0; ex_result = 0;
        mem_rsp_valid = 0; mem_rsp_data = 0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic ld, input logic [31:0] ex);
        idle();
        id_valid = 1; id_rd = rd; id_rd_we = 1; id_is_load = ld; ex_result = ex;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ns, nw;
        for (int i = 0; i < D; i++) pipe[i] = '0;
        wcnt = 0;
        tmo  = 0;
        idle();
        rst = 1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        #1;
        chk("rst_stall", stall, 0);
        chk("rst_mem_wait", mem_wait, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_rd", wb_rd, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_ld_timeout", ld_timeout, 0);
        chk("rst_op_a", op_a, 0);

        // ALU chain
        issue(1, 0, 32'h10); cycle();
        issue(2, 0, 32'h20); id_rs1 = 1; id_rs1_used = 1; #1;
        chk("alu_e0_op_a", op_a, 32'h10);
        chk("alu_e0_stall", stall, 0);
        cycle();
        issue(3, 0, 32'h30); id_rs1 = 1; id_rs1_used = 1; #1;
        chk("alu_e1_op_a", op_a, 32'h10);
        cycle();
        idle(); repeat (3) cycle();

        // Load-use with immediate response
        issue(5, 1, 0); cycle();
        issue(6, 0, 32'h66); id_rs1 = 5; id_rs2 = 5; id_rs1_used = 1; id_rs2_used = 1; #1;
        chk("ldu_stall", stall, 1);
        cycle();
        mem_rsp_valid = 1; mem_rsp_data = 32'hDEADBEEF; #1;
        chk("ldu_op_a", op_a, 32'hDEADBEEF);
        chk("ldu_op_b", op_b, 32'hDEADBEEF);
        chk("ldu_nostall", stall, 0);
        cycle();
        idle(); #1;
        chk("ldu_wb_valid", wb_valid, 1);
        chk("ldu_wb_rd", wb_rd, 5);
        chk("ldu_wb_data", wb_data, 32'hDEADBEEF);
        cycle();
        repeat (3) cycle();

        // Response three cycles late
        issue(5, 1, 0); cycle();
        issue(6, 0, 32'h66); id_rs1 = 5; id_rs1_used = 1;
        ns = 0; nw = 0;
        for (int k = 0; k < 5; k++) begin
            if (k == 4) begin
                mem_rsp_valid = 1; mem_rsp_data = 32'h12345678;
            end
            cycle();
            ns += int'(obs_stall);
            nw += int'(obs_wait);
        end
        chk("dly_stall_cycles", ns, 4);
        chk("dly_wait_cycles", nw, 3);
        idle(); repeat (3) cycle();

        // Priority and x0
        issue(7, 0, 32'hB); cycle();
        issue(7, 0, 32'hA); cycle();
        issue(8, 0, 32'h8); id_rs1 = 7; id_rs1_used = 1; #1;
        chk("prio_op_a", op_a, 32'hA);
        cycle();
        issue(0, 0, 32'h99); cycle();
        issue(9, 0, 32'h9); id_rs1 = 0; id_rs1_used = 1; rf_rs1_data = 32'h55; #1;
        chk("x0_op_a", op_a, 0);
        chk("x0_stall", stall, 0);
        cycle();
        idle(); cycle();
        #1;
        chk("x0_wb_valid", wb_valid, 0);
        cycle();
        repeat (2) cycle();

        // Load never answered
        issue(9, 1, 0); cycle();
        idle(); cycle();
        repeat (4) cycle();
        #1;
        chk("tmo_set", ld_timeout, 1);
        repeat (2) cycle();
        #1;
        chk("tmo_sticky", ld_timeout, 1);
        rst = 1; cycle();
        rst = 0; #1;
        chk("tmo_rst_flag", ld_timeout, 0);
        chk("tmo_rst_wait", mem_wait, 0);
        chk("tmo_rst_stall", stall, 0);
        chk("tmo_rst_wb", wb_valid, 0);
        cycle();

        // clk_en gating
        issue(3, 0, 32'h33); cycle();
        issue(4, 0, 32'h44); id_rs1 = 3; id_rs1_used = 1; clk_en = 0; #1;
        chk("ce_stall", stall, 0);
        chk("ce_wb_valid", wb_valid, 0);
        cycle(); cycle();
        clk_en = 1; #1;
        chk("ce_op_a", op_a, 32'h33);
        chk("ce_resume_stall", stall, 0);
        cycle();
        idle(); repeat (3) cycle();

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            rst           = ($urandom_range(0, 199) == 0);
            clk_en        = ($urandom_range(0, 99) < 85);
            id_valid      = ($urandom_range(0, 99) < 80);
            id_rd         = 5'($urandom_range(0, 3));
            id_rd_we      = ($urandom_range(0, 99) < 85);
            id_is_load    = ($urandom_range(0, 99) < 30);
            id_rs1        = 5'($urandom_range(0, 3));
            id_rs2        = 5'($urandom_range(0, 3));
            id_rs1_used   = $urandom_range(0, 1) == 1;
            id_rs2_used   = $urandom_range(0, 1) == 1;
            rf_rs1_data   = $urandom;
            rf_rs2_data   = $urandom;
            ex_result     = $urandom;
            mem_rsp_valid = $urandom_range(0, 1) == 1;
            mem_rsp_data  = $urandom;
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
